floating_point_softmax_input_stager: RTL

- Transmitter end of the softmax input interface.
- Accepts a serial stream of floating-point logits, one per beat, over a valid/ready handshake.
- Groups beats into vectors of four and tracks the running maximum with a sign-magnitude float compare.
- Presents in1..in4 and max_input stable to the softmax datapath, pulses softmax_enable, then blocks until softmax_output_ready returns.

---
 rtl/floating_point_softmax_input_stager_pkg.sv | 34 +++
 rtl/floating_point_softmax_input_stager_compare.sv | 45 ++++
 rtl/floating_point_softmax_input_stager.sv | 110 +++++++++++
 3 files changed

// File: rtl/floating_point_softmax_input_stager_pkg.sv
// Shared definitions for the softmax input stager.
//   state_t              : stager FSM states (COLLECT, LAUNCH, WAIT)
//   VECTOR_LEN           : number of logits per softmax vector
//   sign_pos / exp_lsb / mag_msb : field positions of a {sign, exp[E], man[M]} float
//   POS_ZERO / NEG_ZERO  : signed-zero bit patterns for the default 32-bit format
package floating_point_softmax_input_stager_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        LAUNCH  = 2'd1,
        WAIT    = 2'd2
    } state_t;

    localparam int VECTOR_LEN = 4;

    // Bit index of the sign bit.
    function automatic int sign_pos(input int e, input int m);
        return e + m;
    endfunction

    // Lowest bit of the exponent field (the mantissa occupies [m-1:0]).
    function automatic int exp_lsb(input int e, input int m);
        return m + (e - e);
    endfunction

    // Top bit of the {exp, man} magnitude field.
    function automatic int mag_msb(input int e, input int m);
        return e + m - 1;
    endfunction

    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

endpackage

// File: rtl/floating_point_softmax_input_stager_compare.sv
// Combinational sign-magnitude float compare.
//   a, b    : {sign, exp[E], man[M]} operands
//   a_lt_b  : 1 when b is strictly greater than a
// +0 and -0 compare equal. NaN/Inf are not special-cased; they order as raw
// sign-magnitude patterns.
module floating_point_compare
    import floating_point_softmax_input_stager_pkg::*;
#(
    parameter int E = 8,
    parameter int M = 23
) (
    input  logic [E+M:0] a,
    input  logic [E+M:0] b,
    output logic         a_lt_b
);

    localparam int SIGN_BIT = sign_pos(E, M);
    localparam int MAG_MSB  = mag_msb(E, M);

    logic           sign_a;
    logic           sign_b;
    logic [E+M-1:0] mag_a;
    logic [E+M-1:0] mag_b;

    assign sign_a = a[SIGN_BIT];
    assign sign_b = b[SIGN_BIT];
    assign mag_a  = a[MAG_MSB:0];
    assign mag_b  = b[MAG_MSB:0];

    always_comb begin
        a_lt_b = 1'b0;
        if ((mag_a == '0) && (mag_b == '0)) begin
            // Both zero, whatever the signs: equal.
            a_lt_b = 1'b0;
        end else if (sign_a != sign_b) begin
            // Differing signs: b wins exactly when a is the negative one.
            a_lt_b = sign_a;
        end else if (!sign_a) begin
            a_lt_b = (mag_a < mag_b);
        end else begin
            a_lt_b = (mag_a > mag_b);
        end
    end

endmodule

// File: rtl/floating_point_softmax_input_stager.sv
// Softmax input stager: collects four float logits from a valid/ready stream,
// tracks their maximum, then presents the vector and its maximum to the softmax
// datapath with a one-cycle launch pulse and waits for completion.
//   clk, reset (async, active-low)
//   in_valid, in_data, in_ready : upstream beat handshake
//   softmax_output_ready        : completion pulse from the datapath
//   in1..in4, max_input         : staged vector and its maximum (held stable)
//   softmax_enable              : one-cycle launch pulse
//   busy                        : vector in flight (LAUNCH or WAIT)
module floating_point_softmax_input_stager
    import floating_point_softmax_input_stager_pkg::*;
#(
    parameter int DATA_WIDTH = 32,   // must equal 1 + E + M
    parameter int E          = 8,
    parameter int M          = 23
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  softmax_output_ready,
    output logic [DATA_WIDTH-1:0] in1,
    output logic [DATA_WIDTH-1:0] in2,
    output logic [DATA_WIDTH-1:0] in3,
    output logic [DATA_WIDTH-1:0] in4,
    output logic [DATA_WIDTH-1:0] max_input,
    output logic                  softmax_enable,
    output logic                  busy
);

    localparam logic [1:0] LAST_BEAT = 2'(VECTOR_LEN - 1);

    state_t                state_reg;
    state_t                state_next;
    logic [1:0]            cnt_reg;
    logic [DATA_WIDTH-1:0] buf_reg [0:VECTOR_LEN-2];
    logic [DATA_WIDTH-1:0] run_max_reg;
    logic [DATA_WIDTH-1:0] vec_reg [0:VECTOR_LEN-1];
    logic [DATA_WIDTH-1:0] max_reg;
    // Holds in_ready low until the first clock after reset release.
    logic                  ready_en_reg;

    logic                  accept;
    logic                  max_lt_in;
    logic [DATA_WIDTH-1:0] greater;

    // One comparator serves both the running-max update on beats 1..2 and
    // the final max on beat 3, since only one beat arrives per cycle.
    floating_point_compare #(
        .E (E),
        .M (M)
    ) u_compare (
        .a      (run_max_reg),
        .b      (in_data),
        .a_lt_b (max_lt_in)
    );

    // Ties keep the running max, so the earliest equal pattern survives.
    assign greater  = max_lt_in ? in_data : run_max_reg;
    assign in_ready = ready_en_reg && (state_reg == COLLECT);
    assign accept   = in_valid && in_ready;

    assign softmax_enable = (state_reg == LAUNCH);
    assign busy           = (state_reg != COLLECT);

    assign in1       = vec_reg[0];
    assign in2       = vec_reg[1];
    assign in3       = vec_reg[2];
    assign in4       = vec_reg[3];
    assign max_input = max_reg;

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            COLLECT: if (accept && (cnt_reg == LAST_BEAT)) state_next = LAUNCH;
            LAUNCH:  state_next = softmax_output_ready ? COLLECT : WAIT;
            WAIT:    if (softmax_output_ready) state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= COLLECT;
            cnt_reg      <= 2'd0;
            run_max_reg  <= '0;
            max_reg      <= '0;
            ready_en_reg <= 1'b0;
            for (int i = 0; i < VECTOR_LEN - 1; i++) buf_reg[i] <= '0;
            for (int i = 0; i < VECTOR_LEN; i++)     vec_reg[i] <= '0;
        end else begin
            ready_en_reg <= 1'b1;
            state_reg    <= state_next;
            if (accept) begin
                if (cnt_reg == LAST_BEAT) begin
                    for (int i = 0; i < VECTOR_LEN - 1; i++) vec_reg[i] <= buf_reg[i];
                    vec_reg[VECTOR_LEN-1] <= in_data;
                    max_reg               <= greater;
                    cnt_reg               <= 2'd0;
                end else begin
                    buf_reg[cnt_reg] <= in_data;
                    run_max_reg      <= (cnt_reg == 2'd0) ? in_data : greater;
                    cnt_reg          <= cnt_reg + 2'd1;
                end
            end
        end
    end

endmodule
